// File: rtl/bp_seq_pkg.sv
// Shared types and constants for the LSTM layer backpropagation sequencer.
package bp_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_DELTA      = 3'd1,
    ST_DOUT_ISSUE = 3'd2,
    ST_DOUT_DRAIN = 3'd3,
    ST_FIN        = 3'd4
  } state_e;

  localparam logic [1:0] GATE_A = 2'd0;
  localparam logic [1:0] GATE_I = 2'd1;
  localparam logic [1:0] GATE_F = 2'd2;
  localparam logic [1:0] GATE_O = 2'd3;

  localparam int DELTA_STEPS = 5;
  localparam int DRAIN_CYC   = 2;

  // Weight mux select for gate g out of the recurrent (U) bank.
  function automatic logic [2:0] u_sel(input logic [1:0] g);
    return {1'b1, g};
  endfunction

endpackage

// File: rtl/bp_seq_addr_gen.sv
// Combinational address compute for the backprop sequencer.
// Inputs are the loop indices (timestep t, cell c, output j, gate g).
module bp_seq_addr_gen #(
  parameter int CELLS = 8,
  parameter int AW    = 9
) (
  input  logic [AW-1:0] t_i,
  input  logic [AW-1:0] c_i,
  input  logic [AW-1:0] j_i,
  input  logic [1:0]    g_i,
  output logic [AW-1:0] dout_rd_o,
  output logic [AW-1:0] dgate_o,
  output logic [AW-1:0] wghts_o,
  output logic [AW-1:0] dout_wr_o
);

  localparam logic [AW-1:0] CELLS_W = AW'(CELLS);
  localparam logic [AW-1:0] CC_W    = AW'(CELLS * CELLS);

  // Delta-out buffer ping-pongs on t parity: read the bank written at t+1, write bank t%2.
  always_comb begin
    dout_rd_o = t_i[0] ? c_i : (CELLS_W + c_i);
    dout_wr_o = t_i[0] ? (CELLS_W + j_i) : j_i;
    dgate_o   = (t_i * CELLS_W) + c_i;
    wghts_o   = (AW'(g_i) * CC_W) + (c_i * CELLS_W) + j_i;
  end

endmodule

// File: rtl/bp_layer_seq.sv
// Initiator-side control sequencer for one LSTM layer's backpropagation datapath.
// Walks timesteps TIMESTEPS-1..0: per-cell delta steps, then recurrent delta-out MAC.
// Optional macro BP_LAYER_SEQ_STALL_EN adds a 'stall' input that freezes the sequencer.
// All outputs are registered from next-state values, so they line up with the state.
module bp_layer_seq
  import bp_seq_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int CELLS     = 8,
  parameter int TIMESTEPS = 7,
  parameter int AW        = 9
) (
  input  logic             clk,
  input  logic             rst,
`ifdef BP_LAYER_SEQ_STALL_EN
  input  logic             stall,
`endif
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [2:0]       delta_phase,
  output logic             dout_zero,
  output logic             load_d_state,
  output logic [WIDTH-1:0] wr_da,
  output logic [WIDTH-1:0] wr_di,
  output logic [WIDTH-1:0] wr_df,
  output logic [WIDTH-1:0] wr_do,
  output logic [WIDTH-1:0] wr_addr_dgate,
  output logic [WIDTH-1:0] rd_addr_dgate,
  output logic [WIDTH-1:0] rd_addr_wghts,
  output logic [1:0]       sel_dgate,
  output logic [2:0]       sel_wghts,
  output logic             acc_mac,
  output logic [WIDTH-1:0] wr_dout,
  output logic [WIDTH-1:0] wr_addr_dout,
  output logic [WIDTH-1:0] rd_addr_dout
);

  localparam logic [AW-1:0] LAST_C = AW'(CELLS - 1);
  localparam logic [AW-1:0] LAST_T = AW'(TIMESTEPS - 1);
  localparam logic [2:0]    LAST_P = 3'(DELTA_STEPS - 1);
  localparam logic          LAST_D = 1'(DRAIN_CYC - 1);

  logic stall_s;
`ifdef BP_LAYER_SEQ_STALL_EN
  assign stall_s = stall;
`else
  assign stall_s = 1'b0;
`endif

  state_e          state_q, state_d;
  logic [AW-1:0]   t_q, t_d, c_q, c_d, j_q, j_d;
  logic [1:0]      g_q, g_d;
  logic [2:0]      p_q, p_d;
  logic            dr_q, dr_d;

  logic            busy_q, busy_d, done_q, done_d;
  logic [2:0]      phase_q, phase_d;
  logic            dz_q, dz_d, load_q, load_d;
  logic            wda_q, wda_d, wdi_q, wdi_d, wdf_q, wdf_d, wdo_q, wdo_d;
  logic            wdout_q, wdout_d;
  logic [AW-1:0]   wa_dg_q, wa_dg_d, ra_dg_q, ra_dg_d, ra_w_q, ra_w_d;
  logic [AW-1:0]   ra_do_q, ra_do_d, wa_do_q, wa_do_d;
  logic [1:0]      sel_dg_q;
  logic [2:0]      sel_w_q;
  logic            acc_q;

  logic [AW-1:0]   gen_dout_rd_s, gen_dgate_s, gen_wghts_s, gen_dout_wr_s;

  bp_seq_addr_gen #(.CELLS(CELLS), .AW(AW)) u_addr_gen (
    .t_i       (t_d),
    .c_i       (c_d),
    .j_i       (j_d),
    .g_i       (g_d),
    .dout_rd_o (gen_dout_rd_s),
    .dgate_o   (gen_dgate_s),
    .wghts_o   (gen_wghts_s),
    .dout_wr_o (gen_dout_wr_s)
  );

  // State and loop counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      t_q     <= '0;
      c_q     <= '0;
      j_q     <= '0;
      g_q     <= 2'd0;
      p_q     <= 3'd0;
      dr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      c_q     <= c_d;
      j_q     <= j_d;
      g_q     <= g_d;
      p_q     <= p_d;
      dr_q    <= dr_d;
    end
  end

  // Next-state and loop counter advance; a stall freezes everything.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    c_d     = c_q;
    j_d     = j_q;
    g_d     = g_q;
    p_d     = p_q;
    dr_d    = dr_q;
    if (stall_s) begin
      state_d = state_q;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_DELTA;
            t_d     = LAST_T;
            c_d     = '0;
            p_d     = 3'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DELTA: begin
          if (p_q == LAST_P) begin
            p_d = 3'd0;
            if (c_q == LAST_C) begin
              c_d = '0;
              if (t_q != '0) begin
                state_d = ST_DOUT_ISSUE;
                j_d     = '0;
                g_d     = GATE_A;
              end else begin
                state_d = ST_FIN;
              end
            end else begin
              c_d = c_q + AW'(1);
            end
          end else begin
            p_d = p_q + 3'd1;
          end
        end
        ST_DOUT_ISSUE: begin
          if (c_q == LAST_C) begin
            c_d = '0;
            if (g_q == GATE_O) begin
              g_d     = GATE_A;
              dr_d    = 1'b0;
              state_d = ST_DOUT_DRAIN;
            end else begin
              g_d = g_q + 2'd1;
            end
          end else begin
            c_d = c_q + AW'(1);
          end
        end
        ST_DOUT_DRAIN: begin
          if (dr_q == LAST_D) begin
            dr_d = 1'b0;
            if (j_q != LAST_C) begin
              j_d     = j_q + AW'(1);
              state_d = ST_DOUT_ISSUE;
            end else begin
              t_d     = t_q - AW'(1);
              c_d     = '0;
              p_d     = 3'd0;
              state_d = ST_DELTA;
            end
          end else begin
            dr_d = dr_q + 1'b1;
          end
        end
        ST_FIN: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Output decode from next state: enables pulse in their slot, addresses hold otherwise.
  always_comb begin
    busy_d  = (state_d != ST_IDLE) && (state_d != ST_FIN);
    done_d  = 1'b0;
    load_d  = 1'b0;
    wda_d   = 1'b0;
    wdi_d   = 1'b0;
    wdf_d   = 1'b0;
    wdo_d   = 1'b0;
    wdout_d = 1'b0;
    phase_d = 3'd0;
    dz_d    = 1'b0;
    wa_dg_d = wa_dg_q;
    ra_dg_d = ra_dg_q;
    ra_w_d  = ra_w_q;
    ra_do_d = ra_do_q;
    wa_do_d = wa_do_q;
    if (stall_s) begin
      phase_d = phase_q;
      dz_d    = dz_q;
    end else begin
      case (state_d)
        ST_DELTA: begin
          phase_d = p_d;
          if (p_d == 3'd0) begin
            ra_do_d = gen_dout_rd_s;
            dz_d    = (t_d == LAST_T);
          end else begin
            wa_dg_d = gen_dgate_s;
          end
          case (p_d)
            3'd1:    wdo_d = 1'b1;
            3'd2:    wda_d = 1'b1;
            3'd3:    wdi_d = 1'b1;
            3'd4: begin
              wdf_d  = 1'b1;
              load_d = 1'b1;
            end
            default: load_d = 1'b0;
          endcase
        end
        ST_DOUT_ISSUE: begin
          ra_dg_d = gen_dgate_s;
          ra_w_d  = gen_wghts_s;
        end
        ST_DOUT_DRAIN: begin
          if (dr_d == LAST_D) begin
            wdout_d = 1'b1;
            wa_do_d = gen_dout_wr_s;
          end else begin
            wdout_d = 1'b0;
          end
        end
        ST_FIN: begin
          done_d = 1'b1;
        end
        default: begin
          done_d = 1'b0;
        end
      endcase
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      phase_q <= 3'd0;
      dz_q    <= 1'b0;
      load_q  <= 1'b0;
      wda_q   <= 1'b0;
      wdi_q   <= 1'b0;
      wdf_q   <= 1'b0;
      wdo_q   <= 1'b0;
      wdout_q <= 1'b0;
      wa_dg_q <= '0;
      ra_dg_q <= '0;
      ra_w_q  <= '0;
      ra_do_q <= '0;
      wa_do_q <= '0;
    end else begin
      busy_q  <= busy_d;
      done_q  <= done_d;
      phase_q <= phase_d;
      dz_q    <= dz_d;
      load_q  <= load_d;
      wda_q   <= wda_d;
      wdi_q   <= wdi_d;
      wdf_q   <= wdf_d;
      wdo_q   <= wdo_d;
      wdout_q <= wdout_d;
      wa_dg_q <= wa_dg_d;
      ra_dg_q <= ra_dg_d;
      ra_w_q  <= ra_w_d;
      ra_do_q <= ra_do_d;
      wa_do_q <= wa_do_d;
    end
  end

  // MAC selects trail the issued read addresses by one cycle to match memory latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_dg_q <= 2'd0;
      sel_w_q  <= 3'd0;
      acc_q    <= 1'b0;
    end else if (!stall_s && (state_q == ST_DOUT_ISSUE)) begin
      sel_dg_q <= g_q;
      sel_w_q  <= u_sel(g_q);
      acc_q    <= !((g_q == GATE_A) && (c_q == '0));
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign delta_phase   = phase_q;
  assign dout_zero     = dz_q;
  assign load_d_state  = load_q;
  assign wr_da         = WIDTH'(wda_q);
  assign wr_di         = WIDTH'(wdi_q);
  assign wr_df         = WIDTH'(wdf_q);
  assign wr_do         = WIDTH'(wdo_q);
  assign wr_dout       = WIDTH'(wdout_q);
  assign wr_addr_dgate = WIDTH'(wa_dg_q);
  assign rd_addr_dgate = WIDTH'(ra_dg_q);
  assign rd_addr_wghts = WIDTH'(ra_w_q);
  assign rd_addr_dout  = WIDTH'(ra_do_q);
  assign wr_addr_dout  = WIDTH'(wa_do_q);
  assign sel_dgate     = sel_dg_q;
  assign sel_wghts     = sel_w_q;
  assign acc_mac       = acc_q;

endmodule

// File: tb/tb_bp_layer_seq.sv
// Self-checking bench for bp_layer_seq: two instances (2 cells x 2 steps, 3 cells x 1 step)
// compared cycle by cycle against a loop-nest reference trace built from the sequencing rules.
module tb_bp_layer_seq;

  localparam int W = 32;

`ifdef BP_LAYER_SEQ_STALL_EN
  localparam bit HAS_STALL = 1'b1;
`else
  localparam bit HAS_STALL = 1'b0;
`endif

  typedef struct packed {
    logic         busy;
    logic         done;
    logic [2:0]   phase;
    logic         dz;
    logic         load;
    logic [W-1:0] wda, wdi, wdf, wdo, wdout;
    logic [W-1:0] wa_dg, ra_dg, ra_w, ra_do, wa_do;
    logic [1:0]   sel_dg;
    logic [2:0]   sel_w;
    logic         acc;
  } cyc_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic stall = 1'b0;

  always #5 clk = ~clk;

  logic a_busy, a_done, a_dz, a_load, a_acc;
  logic [2:0] a_phase, a_sel_w;
  logic [1:0] a_sel_dg;
  logic [W-1:0] a_wda, a_wdi, a_wdf, a_wdo, a_wdout, a_wa_dg, a_ra_dg, a_ra_w, a_ra_do, a_wa_do;
  logic b_busy, b_done, b_dz, b_load, b_acc;
  logic [2:0] b_phase, b_sel_w;
  logic [1:0] b_sel_dg;
  logic [W-1:0] b_wda, b_wdi, b_wdf, b_wdo, b_wdout, b_wa_dg, b_ra_dg, b_ra_w, b_ra_do, b_wa_do;

  bp_layer_seq #(.WIDTH(W), .CELLS(2), .TIMESTEPS(2), .AW(9)) dut_a (
    .clk(clk), .rst(rst),
`ifdef BP_LAYER_SEQ_STALL_EN
    .stall(stall),
`endif
    .start(start_a), .busy(a_busy), .done(a_done), .delta_phase(a_phase),
    .dout_zero(a_dz), .load_d_state(a_load),
    .wr_da(a_wda), .wr_di(a_wdi), .wr_df(a_wdf), .wr_do(a_wdo),
    .wr_addr_dgate(a_wa_dg), .rd_addr_dgate(a_ra_dg), .rd_addr_wghts(a_ra_w),
    .sel_dgate(a_sel_dg), .sel_wghts(a_sel_w), .acc_mac(a_acc),
    .wr_dout(a_wdout), .wr_addr_dout(a_wa_do), .rd_addr_dout(a_ra_do)
  );

  bp_layer_seq #(.WIDTH(W), .CELLS(3), .TIMESTEPS(1), .AW(9)) dut_b (
    .clk(clk), .rst(rst),
`ifdef BP_LAYER_SEQ_STALL_EN
    .stall(stall),
`endif
    .start(start_b), .busy(b_busy), .done(b_done), .delta_phase(b_phase),
    .dout_zero(b_dz), .load_d_state(b_load),
    .wr_da(b_wda), .wr_di(b_wdi), .wr_df(b_wdf), .wr_do(b_wdo),
    .wr_addr_dgate(b_wa_dg), .rd_addr_dgate(b_ra_dg), .rd_addr_wghts(b_ra_w),
    .sel_dgate(b_sel_dg), .sel_wghts(b_sel_w), .acc_mac(b_acc),
    .wr_dout(b_wdout), .wr_addr_dout(b_wa_do), .rd_addr_dout(b_ra_do)
  );

  cyc_t obs_a, obs_b;
  assign obs_a = {a_busy, a_done, a_phase, a_dz, a_load, a_wda, a_wdi, a_wdf, a_wdo, a_wdout,
                  a_wa_dg, a_ra_dg, a_ra_w, a_ra_do, a_wa_do, a_sel_dg, a_sel_w, a_acc};
  assign obs_b = {b_busy, b_done, b_phase, b_dz, b_load, b_wda, b_wdi, b_wdf, b_wdo, b_wdout,
                  b_wa_dg, b_ra_dg, b_ra_w, b_ra_do, b_wa_do, b_sel_dg, b_sel_w, b_acc};

  int   n_total = 0;
  int   n_bad   = 0;
  cyc_t exp_q[$];
  cyc_t h_a = '0;
  cyc_t h_b = '0;

  // Append one visible cycle; MAC selects show what was issued on the previous cycle.
  task automatic push(inout cyc_t h, inout bit pv, inout int pg, inout bit pacc,
                      input bit iss, input int g, input bit acc);
    if (pv) begin
      h.sel_dg = 2'(pg);
      h.sel_w  = {1'b1, 2'(pg)};
      h.acc    = pacc;
    end
    exp_q.push_back(h);
    pv   = iss;
    pg   = g;
    pacc = acc;
  endtask

  task automatic clr(inout cyc_t h);
    h.busy = 1'b0; h.done = 1'b0; h.phase = 3'd0; h.dz = 1'b0; h.load = 1'b0;
    h.wda = '0; h.wdi = '0; h.wdf = '0; h.wdo = '0; h.wdout = '0;
  endtask

  // Reference trace of one full run (first busy cycle through FIN and one idle cycle).
  task automatic build(input int C, input int T, inout cyc_t h);
    bit pv = 1'b0;
    int pg = 0;
    bit pacc = 1'b0;
    exp_q.delete();
    for (int t = T - 1; t >= 0; t--) begin
      for (int c = 0; c < C; c++) begin
        for (int p = 0; p < 5; p++) begin
          clr(h);
          h.busy  = 1'b1;
          h.phase = 3'(p);
          if (p == 0) begin
            h.ra_do = W'(((t + 1) % 2) * C + c);
            h.dz    = (t == T - 1);
          end else begin
            h.wa_dg = W'(t * C + c);
          end
          case (p)
            1: h.wdo = W'(1);
            2: h.wda = W'(1);
            3: h.wdi = W'(1);
            4: begin h.wdf = W'(1); h.load = 1'b1; end
            default: h.load = 1'b0;
          endcase
          push(h, pv, pg, pacc, 1'b0, 0, 1'b0);
        end
      end
      if (t > 0) begin
        for (int j = 0; j < C; j++) begin
          for (int g = 0; g < 4; g++) begin
            for (int c = 0; c < C; c++) begin
              clr(h);
              h.busy  = 1'b1;
              h.ra_dg = W'(t * C + c);
              h.ra_w  = W'(g * C * C + c * C + j);
              push(h, pv, pg, pacc, 1'b1, g, !(g == 0 && c == 0));
            end
          end
          for (int d = 0; d < 2; d++) begin
            clr(h);
            h.busy = 1'b1;
            if (d == 1) begin
              h.wdout = W'(1);
              h.wa_do = W'((t % 2) * C + j);
            end
            push(h, pv, pg, pacc, 1'b0, 0, 1'b0);
          end
        end
      end
    end
    clr(h);
    h.done = 1'b1;
    push(h, pv, pg, pacc, 1'b0, 0, 1'b0);
    clr(h);
    push(h, pv, pg, pacc, 1'b0, 0, 1'b0);
  endtask

  task automatic chk_int(input string tag, input int got, input int want);
    n_total++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  // Start one run on instance 'which' and compare every cycle against the reference.
  task automatic run(input int which, input int C, input int T, input bit rnd, input int force_at);
    cyc_t e, o;
    int i = 0, cyc = 0, first_busy = -1, done_at = -1, n_done = 0, forced = 0, n_stall = 0;
    int n_da = 0, n_di = 0, n_df = 0, n_do = 0, n_dout = 0, n_dz = 0, n_ld = 0;
    bit stl = 1'b0, prev_stl = 1'b0;
    if (which == 0) build(C, T, h_a); else build(C, T, h_b);
    @(negedge clk);
    if (which == 0) start_a = 1'b1; else start_b = 1'b1;
    e = exp_q[0];
    while (i < exp_q.size()) begin
      @(negedge clk);
      o = (which == 0) ? obs_a : obs_b;
      n_total++;
      assert (o === e) else begin
        n_bad++;
        $error("FAIL trace%0d step %0d: got %h want %h", which, i, o, e);
      end
      if (o.busy && first_busy < 0) first_busy = cyc;
      if (o.done) begin n_done++; done_at = cyc; end
      n_da   += (o.wda != '0) ? 1 : 0;
      n_di   += (o.wdi != '0) ? 1 : 0;
      n_df   += (o.wdf != '0) ? 1 : 0;
      n_do   += (o.wdo != '0) ? 1 : 0;
      n_dout += (o.wdout != '0) ? 1 : 0;
      n_ld   += o.load ? 1 : 0;
      n_dz   += (o.dz && !prev_stl) ? 1 : 0;
      prev_stl = stl;
      stl = 1'b0;
      if (HAS_STALL && i < exp_q.size() - 1) begin
        if (i == force_at && forced < 3) begin
          stl = 1'b1;
          forced++;
        end else if (rnd && $urandom_range(0, 7) == 0) begin
          stl = 1'b1;
        end
      end
      stall = stl;
      if (which == 0) start_a = rnd && (i < exp_q.size() - 1) && ($urandom_range(0, 1) == 1);
      else            start_b = rnd && (i < exp_q.size() - 1) && ($urandom_range(0, 1) == 1);
      if (stl) begin
        if (done_at < 0) n_stall++;
        e.wda = '0; e.wdi = '0; e.wdf = '0; e.wdo = '0; e.wdout = '0;
        e.load = 1'b0; e.done = 1'b0;
      end else begin
        i++;
        if (i < exp_q.size()) e = exp_q[i];
      end
      cyc++;
      if (cyc > 5000) begin
        n_total++; n_bad++;
        $display("FAIL timeout: got %0d cycles want under 5000", cyc);
        break;
      end
    end
    stall = 1'b0; start_a = 1'b0; start_b = 1'b0;
    chk_int("done_pulses", n_done, 1);
    chk_int("busy_to_done", done_at - first_busy, 5 * C * T + (T - 1) * C * (4 * C + 2) + n_stall);
    chk_int("wr_da_count", n_da, C * T);
    chk_int("wr_di_count", n_di, C * T);
    chk_int("wr_df_count", n_df, C * T);
    chk_int("wr_do_count", n_do, C * T);
    chk_int("load_count", n_ld, C * T);
    chk_int("wr_dout_count", n_dout, C * (T - 1));
    chk_int("dout_zero_count", n_dz, C);
  endtask

  initial begin
    @(negedge clk);
    n_total++;
    assert (obs_a === '0) else begin n_bad++; $error("FAIL reset_a: got %h want 0", obs_a); end
    n_total++;
    assert (obs_b === '0) else begin n_bad++; $error("FAIL reset_b: got %h want 0", obs_b); end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run(0, 2, 2, 1'b0, -1);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    run(0, 2, 2, 1'b1, 12);
    run(1, 3, 1, 1'b1, -1);
    run(1, 3, 1, 1'b0, -1);

    // Abort a run with an asynchronous reset in its twelfth cycle.
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (11) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_total++;
    assert (obs_a === '0) else begin n_bad++; $error("FAIL abort_a: got %h want 0", obs_a); end
    n_total++;
    assert (obs_b === '0) else begin n_bad++; $error("FAIL abort_b: got %h want 0", obs_b); end
    h_a = '0;
    h_b = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_total++;
      assert ({a_busy, a_done} === 2'b00) else begin
        n_bad++;
        $error("FAIL abort_idle: got busy/done %b%b want 00", a_busy, a_done);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    run(0, 2, 2, 1'b1, -1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
